// File: rtl/result_monitor.sv
// Windowed monitor of a 1-bit signal: counts high samples and rising edges over win_len cycles.
// Optional feature: define MON_SYNC_EN to pass din through a two-flop synchronizer first.
module result_monitor #(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ack,
  output logic             busy,
  output logic             res_valid,
  output logic [WIN_W-1:0] high_cnt,
  output logic [WIN_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIN_W-1:0] r_remain;
  logic [WIN_W-1:0] r_high;
  logic [WIN_W-1:0] r_edge;
  logic             r_prev;
  logic             w_din;
  logic             w_start_ok;
  logic             w_last;
  logic             w_rise;

`ifdef MON_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], din};
    end
  end

  assign w_din = r_sync[1];
`else
  assign w_din = din;
`endif

  // A zero-length request never opens a window, so earlier results survive it.
  assign w_start_ok = start && (win_len != '0);
  assign w_last     = (r_remain == {{(WIN_W-1){1'b0}}, 1'b1});
  assign w_rise     = w_din & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_next = S_MEASURE;
      S_MEASURE: if (w_last)     w_state_next = S_DONE;
      S_DONE:    if (ack)        w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_MEASURE);
    res_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remain <= '0;
      r_high   <= '0;
      r_edge   <= '0;
      r_prev   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_remain <= win_len;
            r_high   <= '0;
            r_edge   <= '0;
            r_prev   <= w_din;
          end
        end
        S_MEASURE: begin
          r_high   <= r_high + {{(WIN_W-1){1'b0}}, w_din};
          r_edge   <= r_edge + {{(WIN_W-1){1'b0}}, w_rise};
          r_prev   <= w_din;
          r_remain <= r_remain - {{(WIN_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  assign high_cnt = r_high;
  assign edge_cnt = r_edge;

endmodule

// File: doc/result_monitor.md
RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 The block SHALL have parameter WIN_W, default 8, setting the width of the window length and both result counters.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, 1 bit, the observed signal, driven by the OR-combining stage output (out1).
REQ-005 The block SHALL have port start, input, 1 bit, which requests a measurement window.
REQ-006 The block SHALL have port win_len, input, WIN_W bits, giving the window length in clk cycles, captured at start.
REQ-007 The block SHALL have port ack, input, 1 bit, with which the consumer accepts the presented result.
REQ-008 The block SHALL have port busy, output, 1 bit, high in MEASURE.
REQ-009 The block SHALL have port res_valid, output, 1 bit, high in DONE.
REQ-010 The block SHALL have port high_cnt, output, WIN_W bits, giving the number of window samples with din=1.
REQ-011 The block SHALL have port edge_cnt, output, WIN_W bits, giving the number of 0->1 transitions of din inside the window.

Function
REQ-012 The block SHALL implement states IDLE, MEASURE and DONE, with busy and res_valid decoded directly from the state.
REQ-013 In IDLE, start=1 with win_len!=0 sampled at edge E SHALL load a remaining-cycle counter with win_len, clear high_cnt/edge_cnt, load prev with the current din sample, and enter MEASURE.
REQ-014 In IDLE, start=1 with win_len=0 SHALL be ignored: the state stays IDLE and the previous results are retained.
REQ-015 In MEASURE, din SHALL be sampled at edges E+1..E+win_len; each sample SHALL add din to high_cnt, add (din & ~prev) to edge_cnt, then update prev to din.
REQ-016 At edge E+win_len the state SHALL become DONE, so res_valid is high from that edge onward.
REQ-017 Counters SHALL NOT saturate or wrap, since high_cnt <= win_len <= 2^WIN_W-1 and edge_cnt <= high_cnt.
REQ-018 In DONE, ack=1 SHALL return the state to IDLE at the next edge, and res_valid SHALL drop.
REQ-019 high_cnt and edge_cnt SHALL hold their values in DONE and in IDLE until the next accepted start.
REQ-020 start SHALL be ignored in MEASURE and DONE, including start and ack both high in DONE: the state goes to IDLE and no new window begins.
REQ-021 ack SHALL be ignored in IDLE and MEASURE.
REQ-022 win_len changes after capture SHALL NOT affect the running window.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and set busy, res_valid, high_cnt, edge_cnt, prev and the internal counter to 0.
REQ-024 Reset asserted mid-MEASURE or mid-DONE SHALL abort the window; after release the block SHALL wait for a new start.

Configuration
REQ-025 When macro MON_SYNC_EN is defined, din SHALL pass through a two-flop synchronizer, reset to 0, before all sampling in REQ-013 and REQ-015, adding 2 cycles of input delay.
REQ-026 When MON_SYNC_EN is undefined, din SHALL be sampled directly with no added delay or flops.

Verification
REQ-027 The bench SHALL cover: din held 1, win_len=4, start pulse -> res_valid high at edge E+4, high_cnt=4, edge_cnt=0.
REQ-028 The bench SHALL cover: din=0 at E, then 1,0,1,0,1,0,1,0, win_len=8 -> high_cnt=4, edge_cnt=4, busy high for exactly 8 cycles.
REQ-029 The bench SHALL cover: win_len=0 with start -> busy and res_valid stay 0, and prior results are unchanged.
REQ-030 The bench SHALL cover: rst_n pulled low 3 cycles into a win_len=10 window -> all outputs 0 at once, state IDLE, and no res_valid afterwards.
REQ-031 The bench SHALL cover: start and ack high together in DONE -> IDLE next edge, busy stays 0; a later start alone starts a new window.
REQ-032 The bench SHALL cover: win_len=255 with din held 1 -> high_cnt=255, no wrap; rerun with MON_SYNC_EN defined -> identical counts for a stable din held 3+ cycles before start.
